input_conditioner: RTL and testbench

Synchronizes and debounces the board's raw user inputs before they reach the memory-mapped peripheral read path. It drives the `switches` and `button` inputs of the data memory, which are read at 0xC000_0000 and 0xC000_0010. The raw active-low pushbutton is filtered by a counter-based debounce FSM and converted into a sticky "enter" flag. The flag is held until software acknowledges it. The slide switches are passed through a 2-flop synchronizer.

---
 rtl/input_conditioner_if.sv | 21 ++
 rtl/input_conditioner.sv | 127 ++++++++++++
 tb/tb_input_conditioner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// User-input bundle between the raw board pins, the conditioner and the
// data-memory peripheral read path.
interface input_conditioner_if;
  logic       key_n;
  logic [9:0] sw_raw;
  logic       clr;
  logic [9:0] switches;
  logic       button;
  logic       btn_level;
  logic       btn_rise;

  modport master (
    output key_n, sw_raw, clr,
    input  switches, button, btn_level, btn_rise
  );

  modport slave (
    input  key_n, sw_raw, clr,
    output switches, button, btn_level, btn_rise
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes the slide switches and debounces the active-low pushbutton
// into a level, a press pulse and a sticky "enter" flag cleared by software.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic               clk,
  input logic               reset_n,
  input_conditioner_if.slave io
);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_key_s1;
  logic             r_key_s2;
  logic [9:0]       r_sw_s1;
  logic [9:0]       r_sw_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_level;
  logic             r_btn_rise;
  logic             r_button;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_rise_next;
  logic             w_level_next;
  logic             w_p;

  // Two-flop synchronizers; the key idles at the released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= io.key_n;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= io.sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign w_p = ~r_key_s2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rise_next  = 1'b0;
    unique case (r_state)
      ST_RELEASED: begin
        if (w_p) begin
          w_state_next = ST_PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_p) begin
          w_state_next = ST_RELEASED;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!w_p) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_p) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_next = ST_RELEASED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RELEASED;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Level follows the next state so it flips on the same edge as the FSM.
  assign w_level_next = (w_state_next == ST_PRESSED) ||
                        (w_state_next == ST_RELEASE_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RELEASED;
      r_cnt       <= '0;
      r_btn_level <= 1'b0;
      r_btn_rise  <= 1'b0;
      r_button    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_btn_level <= w_level_next;
      r_btn_rise  <= w_rise_next;
      // A visible rise pulse also sets, so an ack landing on it loses.
      r_button    <= w_rise_next | r_btn_rise | (r_button & ~io.clr);
    end
  end

  assign io.switches  = r_sw_s2;
  assign io.button    = r_button;
  assign io.btn_level = r_btn_level;
  assign io.btn_rise  = r_btn_rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window;
// each tick() is one rising edge, outputs sampled 1 time unit after it.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_switches"}, 32'(bus.switches), 32'h0);
    check_eq({tag, "_button"},   32'(bus.button),   32'h0);
    check_eq({tag, "_level"},    32'(bus.btn_level), 32'h0);
    check_eq({tag, "_rise"},     32'(bus.btn_rise),  32'h0);
  endtask

  initial begin
    // 1. Reset values and switch synchronizer latency
    reset_n     = 1'b0;
    bus.key_n   = 1'b0;
    bus.sw_raw  = 10'h3FF;
    bus.clr     = 1'b0;
    #3;
    check_all_zero("rst_async");
    tick();
    tick();
    check_all_zero("rst_held");
    reset_n   = 1'b1;
    bus.key_n = 1'b1;
    tick();
    check_eq("sw_edge0", 32'(bus.switches), 32'h0);
    tick();
    check_eq("sw_edge1", 32'(bus.switches), 32'h3FF);
    bus.sw_raw = 10'h2A5;
    tick();
    check_eq("sw2_edge0", 32'(bus.switches), 32'h3FF);
    tick();
    check_eq("sw2_edge1", 32'(bus.switches), 32'h2A5);
    $display("scenario reset/switches done");

    // 2. Clean press
    bus.key_n = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      check_eq("press_rise",   32'(bus.btn_rise),  32'(e == 6));
      check_eq("press_level",  32'(bus.btn_level), 32'(e >= 6));
      check_eq("press_button", 32'(bus.button),    32'(e >= 6));
    end
    $display("scenario clean press done");

    // 4a. Acknowledge clears the flag
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_eq("ack_button", 32'(bus.button), 32'h0);
    check_eq("ack_level",  32'(bus.btn_level), 32'h1);
    tick();
    check_eq("ack_hold", 32'(bus.button), 32'h0);

    // 5a. Release
    bus.key_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      check_eq("rel_level", 32'(bus.btn_level), 32'(e < 6));
      check_eq("rel_rise",  32'(bus.btn_rise),  32'h0);
    end
    $display("scenario release done");

    // 3. Bounce: low x3, high x1, then low held; final low sample is edge 4
    for (int e = 0; e <= 15; e++) begin
      bus.key_n = (e == 3);
      tick();
      check_eq("bounce_rise",   32'(bus.btn_rise),  32'(e == 10));
      check_eq("bounce_level",  32'(bus.btn_level), 32'(e >= 10));
      check_eq("bounce_button", 32'(bus.button),    32'(e >= 10));
    end
    $display("scenario bounce done");

    // 4b. Acknowledge coincident with the rise pulse
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_eq("ack2_button", 32'(bus.button), 32'h0);
    bus.key_n = 1'b1;
    for (int e = 0; e <= 7; e++) tick();
    check_eq("rel2_level", 32'(bus.btn_level), 32'h0);
    bus.key_n = 1'b0;
    for (int e = 0; e <= 6; e++) tick();
    check_eq("coinc_rise_pre",   32'(bus.btn_rise), 32'h1);
    check_eq("coinc_button_pre", 32'(bus.button),   32'h1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_eq("coinc_button", 32'(bus.button),   32'h1);
    check_eq("coinc_rise",   32'(bus.btn_rise), 32'h0);
    $display("scenario coincident ack done");

    // 5b. Re-press after two high samples during RELEASE_WAIT
    for (int e = 0; e <= 11; e++) begin
      bus.key_n = (e < 2);
      tick();
      check_eq("repress_level", 32'(bus.btn_level), 32'h1);
      check_eq("repress_rise",  32'(bus.btn_rise),  32'h0);
    end
    check_eq("repress_button", 32'(bus.button), 32'h1);
    $display("scenario re-press done");

    // 6. Reset while PRESS_WAIT holds counter = 2
    bus.key_n = 1'b1;
    for (int e = 0; e <= 7; e++) tick();
    check_eq("pre6_level", 32'(bus.btn_level), 32'h0);
    bus.key_n = 1'b0;
    for (int e = 0; e <= 4; e++) tick();
    check_eq("pre6_button", 32'(bus.button), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_button", 32'(bus.button),    32'h0);
    check_eq("midrst_level",  32'(bus.btn_level), 32'h0);
    check_eq("midrst_rise",   32'(bus.btn_rise),  32'h0);
    check_eq("midrst_sw",     32'(bus.switches),  32'h0);
    tick();
    reset_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      check_eq("postrst_rise",   32'(bus.btn_rise),  32'(e == 6));
      check_eq("postrst_level",  32'(bus.btn_level), 32'(e >= 6));
      check_eq("postrst_button", 32'(bus.button),    32'(e >= 6));
    end
    $display("scenario reset mid-debounce done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
